dsp_addsub_arbiter: RTL and testbench
=====================================

Name: dsp_addsub_arbiter

Overview:
Shares one saturating fixed-point add/sub datapath (Q15.16, 32-bit signed) between N_REQ requesters, such as the pipeline ALU port and DSP co-processor lanes. Each requester uses a valid/ready handshake. A round-robin arbiter picks one requester per cycle. The selected operation is computed with saturation and returned through a one-deep registered response stage with backpressure. Per-requester sticky saturation flags act as status bits for CSR readback.

Parameters:
N_REQ, 4, number of requesters (2..8)
NB_DATA, 32, operand/result width
NBF_DATA, 16, fractional bits (informational; add/sub is format-agnostic)
ID_W, $clog2(N_REQ), response id width (localparam)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  N_REQ  request valid per requester
req_ready  out  N_REQ  request accepted this cycle (one-hot or zero)
req_op  in  N_REQ  per requester: 0 = a+b, 1 = a-b
req_a  in  N_REQ*NB_DATA  operand a, requester i at [i*NB_DATA +: NB_DATA]
req_b  in  N_REQ*NB_DATA  operand b, same packing
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_data  out  NB_DATA  saturated result
rsp_id  out  ID_W  index of requester that issued it
rsp_sat  out  1  result was clamped
sat_sticky  out  N_REQ  sticky saturation flag per requester
sat_clr  in  N_REQ  clear sticky flag (pulse)

Behaviour:
- Reset (rst_n=0 at posedge): rsp_valid=0, rsp_data=0, rsp_id=0, rsp_sat=0, sat_sticky=0, rr_ptr=0. Any pending response is dropped. req_ready is combinational and is 0 while rsp_valid=0 and no valid requests exist.
- can_issue = !rsp_valid || rsp_ready.
- Grant (combinational): pick the first i with req_valid[i]=1, scanning cyclically from rr_ptr. req_ready[grant]=can_issue; all other bits are 0. No grant when req_valid=0.
- Handshake fire = req_valid[g] && req_ready[g]. On fire:
  - the output register loads the result, rsp_id=g, rsp_sat;
  - rsp_valid=1;
  - rr_ptr = (g+1) mod N_REQ.
- Without fire: rr_ptr holds.
- Latency is 1 cycle, from fire to rsp_valid. Throughput is one operation per cycle while rsp_ready=1.
- Response drain: if rsp_valid && rsp_ready && !fire, then rsp_valid clears next cycle. If drain and fire occur in the same cycle, the register is overwritten and rsp_valid stays 1.
- While rsp_valid && !rsp_ready: rsp_data, rsp_id and rsp_sat are held stable, and all req_ready=0.
- Requesters hold req_valid, req_op and operands stable until ready. The arbiter does not re-sample a dropped valid.
- Arithmetic:
  - Sign-extend a and b to 33 bits; compute a+b or a-b.
  - If bits [32:31] are equal, the result is bits [31:0] and rsp_sat=0.
  - Otherwise, bit32=1 gives 0x80000000, bit32=0 gives 0x7FFFFFFF, and rsp_sat=1.
- sat_sticky[i] sets on a fire from requester i with saturation. It clears on sat_clr[i]. If set and clear occur in the same cycle, set wins.
- Out-of-range rr_ptr is unreachable: the pointer wraps explicitly at N_REQ-1 to 0, including for non-power-of-2 N_REQ.

Decomposition:
- Shared package dsp_pkg:
  - NB_DATA, NBF_DATA;
  - OP_ADD=1'b0, OP_SUB=1'b1;
  - SAT_MAX=32'h7FFFFFFF, SAT_MIN=32'h80000000.
- Sub-module dsp_sat_addsub is purely combinational, taking a, b and op and returning result and sat. It is instantiated once in the arbiter.
- The arbiter, pointer, output register and sticky flags live in the top module.

Test Plan:
1. Single subtract: req0 with a=0x00030000, b=0x00010000, op=1. req_ready[0]=1 the same cycle. Next cycle: rsp_valid=1, rsp_data=0x00020000, rsp_id=0, rsp_sat=0.
2. Positive overflow: req1 with a=0x7FFF0000, b=0x00020000, op=0. Response: rsp_data=0x7FFFFFFF, rsp_sat=1, sat_sticky=4'b0010. Then pulse sat_clr[1] and check sat_sticky=0. Finally, assert sat_clr[1] in the same cycle as a new saturating fire from requester 1 and check sat_sticky[1] stays 1.
3. Negative saturation: req2 with a=0x80000000, b=0x00000001, op=1 gives 0x80000000 with rsp_sat=1. Also a=0xFFFF0000, b=0x00010000, op=0 gives 0x00000000 with rsp_sat=0.
4. Round-robin fairness: all four req_valid held high with rsp_ready=1. rsp_id sequence is 0,1,2,3,0,1 on consecutive cycles. Then drop req_valid[1] with rr_ptr=1 and check the next grant goes to 2.
5. Backpressure: hold rsp_ready=0 for 3 cycles with rsp_valid=1. All req_ready=0 and the response fields are unchanged. Raise rsp_ready: the pending requester fires the same cycle and rsp_valid stays 1 with the new rsp_id.
6. Reset mid-operation: pull rst_n=0 for one cycle while rsp_valid=1 and rr_ptr=2. After the edge: rsp_valid=0, sat_sticky=0, and the next grant scans from requester 0.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared definitions for the saturating fixed-point add/sub datapath.
// The datapath operates on Q15.16 values.
package dsp_pkg;

    localparam int NB_DATA  = 32;
    localparam int NBF_DATA = 16;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_MIN = 32'h8000_0000;

endpackage

// File: rtl/dsp_sat_addsub.sv
// Combinational saturating two's-complement add/sub.
// Overflow is detected from one guard bit above the result width.
module dsp_sat_addsub #(
    parameter int NB_DATA = 32
) (
    input  logic [NB_DATA-1:0] i_a,
    input  logic [NB_DATA-1:0] i_b,
    input  logic               i_op,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_sat
);
    import dsp_pkg::*;

    logic [NB_DATA:0] w_ext_a;
    logic [NB_DATA:0] w_ext_b;
    logic [NB_DATA:0] w_sum;

    always_comb begin
        w_ext_a = {i_a[NB_DATA-1], i_a};
        w_ext_b = {i_b[NB_DATA-1], i_b};
        w_sum   = (i_op == OP_SUB) ? (w_ext_a - w_ext_b) : (w_ext_a + w_ext_b);
        o_result = w_sum[NB_DATA-1:0];
        o_sat    = 1'b0;
        // Differing top two bits mean the true result left the signed range
        if (w_sum[NB_DATA] != w_sum[NB_DATA-1]) begin
            o_sat    = 1'b1;
            o_result = w_sum[NB_DATA] ? {1'b1, {(NB_DATA-1){1'b0}}}
                                      : {1'b0, {(NB_DATA-1){1'b1}}};
        end
    end

endmodule

// File: rtl/dsp_addsub_arbiter.sv
// Round-robin arbiter sharing one saturating add/sub unit among N_REQ requesters,
// with a one-deep registered response stage and per-requester sticky saturation flags.
module dsp_addsub_arbiter #(
    parameter int N_REQ    = 4,
    parameter int NB_DATA  = 32,
    parameter int NBF_DATA = 16,
    localparam int ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ-1:0]         req_op,
    input  logic [N_REQ*NB_DATA-1:0] req_a,
    input  logic [N_REQ*NB_DATA-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [NB_DATA-1:0]       rsp_data,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     rsp_sat,
    output logic [N_REQ-1:0]         sat_sticky,
    input  logic [N_REQ-1:0]         sat_clr
);
    import dsp_pkg::*;

    if (NBF_DATA >= NB_DATA) begin : g_bad_format
        $error("NBF_DATA must be smaller than NB_DATA");
    end

    logic [ID_W-1:0]    r_rr_ptr;
    logic               r_rsp_valid;
    logic [NB_DATA-1:0] r_rsp_data;
    logic [ID_W-1:0]    r_rsp_id;
    logic               r_rsp_sat;
    logic [N_REQ-1:0]   r_sticky;

    logic [ID_W-1:0]    w_grant;
    logic               w_found;
    logic               w_can_issue;
    logic               w_fire;
    int unsigned        w_idx;
    logic [NB_DATA-1:0] w_a;
    logic [NB_DATA-1:0] w_b;
    logic               w_op;
    logic [NB_DATA-1:0] w_result;
    logic               w_sat;
    logic [N_REQ-1:0]   w_set;

    assign w_can_issue = !r_rsp_valid || rsp_ready;

    // Cyclic scan starting at the pointer; index wraps explicitly for any N_REQ
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_idx = 32'(r_rr_ptr) + k;
            if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_grant = ID_W'(w_idx);
            end
        end
    end

    assign w_fire = w_found && w_can_issue;

    always_comb begin
        req_ready = '0;
        if (w_fire) req_ready[w_grant] = 1'b1;
    end

    assign w_a  = req_a[32'(w_grant)*NB_DATA +: NB_DATA];
    assign w_b  = req_b[32'(w_grant)*NB_DATA +: NB_DATA];
    assign w_op = req_op[w_grant];

    dsp_sat_addsub #(
        .NB_DATA (NB_DATA)
    ) u_addsub (
        .i_a      (w_a),
        .i_b      (w_b),
        .i_op     (w_op),
        .o_result (w_result),
        .o_sat    (w_sat)
    );

    // req_ready is one-hot on a fire, so it doubles as the sticky set mask
    assign w_set = req_ready & {N_REQ{w_sat}};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
            r_rsp_sat   <= 1'b0;
            r_sticky    <= '0;
        end else begin
            if (w_fire) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= w_result;
                r_rsp_id    <= w_grant;
                r_rsp_sat   <= w_sat;
                r_rr_ptr    <= (w_grant == ID_W'(N_REQ - 1)) ? '0 : w_grant + 1'b1;
            end else if (rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
            r_sticky <= (r_sticky & ~sat_clr) | w_set;
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_id     = r_rsp_id;
    assign rsp_sat    = r_rsp_sat;
    assign sat_sticky = r_sticky;

endmodule

// File: tb/tb_dsp_addsub_arbiter.sv
// Randomized scoreboard bench for dsp_addsub_arbiter against a behavioural
// model using plain integer arithmetic and a cyclic-priority grant rule.
module tb_dsp_addsub_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   req_op = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [W-1:0]   rsp_data;
    logic [IW-1:0]  rsp_id;
    logic           rsp_sat;
    logic [N-1:0]   sat_sticky;
    logic [N-1:0]   sat_clr = '0;

    dsp_addsub_arbiter #(
        .N_REQ    (N),
        .NB_DATA  (W),
        .NBF_DATA (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .rsp_sat    (rsp_sat),
        .sat_sticky (sat_sticky),
        .sat_clr    (sat_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  data;
        logic [IW-1:0] id;
        logic          sat;
    } rsp_t;

    rsp_t q[$];
    int checks = 0;
    int errors = 0;

    bit           pend [N];
    logic [W-1:0] pa   [N];
    logic [W-1:0] pb   [N];
    logic         pop_ [N];

    int           m_rr = 0;
    bit           m_rv = 0;
    logic [N-1:0] m_sticky = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'h0000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'h0001_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic void ref_addsub(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic op, output logic [W-1:0] r,
                                       output logic s);
        longint x = longint'($signed(a));
        longint y = longint'($signed(b));
        longint t = op ? (x - y) : (x + y);
        s = 1'b0;
        if (t > 64'sd2147483647) begin
            r = 32'h7FFF_FFFF;
            s = 1'b1;
        end else if (t < -64'sd2147483648) begin
            r = 32'h8000_0000;
            s = 1'b1;
        end else begin
            r = t[W-1:0];
        end
    endfunction

    // Monitor: a response handshake is visible at the negedge before the capturing posedge
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected actual=id%0d required=none", rsp_id);
            end else begin
                rsp_t e;
                e = q.pop_front();
                chk("rsp_data", 64'(rsp_data), 64'(e.data));
                chk("rsp_id",   64'(rsp_id),   64'(e.id));
                chk("rsp_sat",  64'(rsp_sat),  64'(e.sat));
            end
        end
    end

    task automatic cycle(input bit do_rst, input int p_new, input int p_ready, input int p_clr);
        int g;
        bit can;
        logic [N-1:0] exp_ready;
        logic [N-1:0] set;
        rsp_t e;
        @(posedge clk);
        #1;
        rst_n = !do_rst;
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 99) < p_new) begin
                pend[i] = 1;
                pa[i]   = pick_operand();
                pb[i]   = pick_operand();
                pop_[i] = $urandom_range(0, 1) == 1;
            end
            req_valid[i]      = pend[i] && !do_rst;
            req_op[i]         = pop_[i];
            req_a[i*W +: W]   = pa[i];
            req_b[i*W +: W]   = pb[i];
            sat_clr[i]        = $urandom_range(0, 99) < p_clr;
        end
        rsp_ready = $urandom_range(0, 99) < p_ready;
        @(negedge clk);
        if (do_rst) begin
            m_rr = 0;
            m_rv = 0;
            m_sticky = '0;
            q.delete();
            return;
        end
        chk("rsp_valid", 64'(rsp_valid), 64'(m_rv));
        chk("sat_sticky", 64'(sat_sticky), 64'(m_sticky));
        g = -1;
        for (int k = 0; k < N; k++) begin
            if (g < 0 && req_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
        end
        can = !m_rv || rsp_ready;
        exp_ready = '0;
        if (g >= 0 && can) exp_ready[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        set = '0;
        if (exp_ready != '0) begin
            ref_addsub(pa[g], pb[g], pop_[g], e.data, e.sat);
            e.id = IW'(g);
            q.push_back(e);
            pend[g] = 0;
            m_rr = (g + 1) % N;
            if (e.sat) set[g] = 1'b1;
            m_rv = 1;
        end else if (rsp_ready) begin
            m_rv = 0;
        end
        m_sticky = (m_sticky & ~sat_clr) | set;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            pend[i] = 0;
            pa[i]   = '0;
            pb[i]   = '0;
            pop_[i] = 1'b0;
        end
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 100, 0);
        chk("reset_rsp_data", 64'(rsp_data), 64'd0);
        chk("reset_rsp_id",   64'(rsp_id),   64'd0);
        chk("reset_rsp_sat",  64'(rsp_sat),  64'd0);
        for (int n = 0; n < 200; n++) cycle(0, 100, 100, 10);
        for (int n = 0; n < 600; n++) cycle(0, 50, 60, 20);
        for (int n = 0; n < 100; n++) cycle(0, 100, 30, 25);
        cycle(1, 50, 60, 0);
        for (int n = 0; n < 300; n++) cycle(0, 50, 60, 20);
        for (int n = 0; n < 30 && (q.size() != 0 || m_rv); n++) cycle(0, 0, 100, 0);
        chk("drain_queue_empty", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
